// File: rtl/ps2_space_decoder.sv
// ps2_space_decoder
//   PS/2 keyboard receiver that tracks one scancode (Space by default). It
//   holds press/release events in a small latch until the processor
//   acknowledges them.
//
//   Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity.
//   Without it, the parity bit is sampled and then ignored.
//
// Ports
//   clock             system clock, rising edge
//   resetn            asynchronous active-low reset
//   ps2_clock         raw PS/2 clock (asynchronous)
//   ps2_data          raw PS/2 data (asynchronous)
//   reset_space_state processor acknowledge, level-sensitive
//   space_state       0 none, 1 press pending, 2 release pending
//   rx_byte           last correctly framed byte
//   rx_valid          one-cycle strobe, rx_byte valid
//   frame_error       one-cycle strobe on bad start/parity/stop/timeout
//
// Frame FSM states
//   state  | meaning
//   IDLE   | waiting for a start bit
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | checking the stop bit, delivering the byte
module ps2_space_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SPACE_CODE     = 8'h29
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       reset_space_state,
  output logic [1:0] space_state,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          falling;
  logic          data_bit;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] tmo_cnt;
  logic          parity_ok;

  logic          ext;
  logic          brk;
  logic          key_down;
  logic          held_release;
  logic          is_space;
  logic          press_ev;
  logic          rel_ev;
  logic [1:0]    next_state;
  logic          next_held;

  // Sync flops reset low so that an idle-high line after reset is seen as a
  // rising edge and never as a false start bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= 2'b00;
      dat_sync <= 2'b00;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign falling  = clk_prev & ~clk_sync[1];
  assign data_bit = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  // Odd parity: data bits plus the parity bit hold an odd number of ones.
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // The timeout counter is a down-counter reloaded on every PS/2 falling
  // edge. When it reaches zero, TIMEOUT_CYCLES cycles have passed with no edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      tmo_cnt     <= '0;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      if (falling)
        tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;

      case (state)
        IDLE: if (falling) begin
          if (!data_bit) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end else begin
            frame_error <= 1'b1;
          end
        end
        DATA: if (falling) begin
          shift   <= {data_bit, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= PARITY;
        end
        PARITY: if (falling) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_bit <= data_bit;
`endif
          state <= STOP;
        end
        STOP: if (falling) begin
          if (data_bit && parity_ok) begin
            rx_byte  <= shift;
            rx_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && !falling && tmo_cnt == '0) begin
        state       <= IDLE;
        frame_error <= 1'b1;
      end
    end
  end

  // Prefix bytes are checked first, so an E0/F0 byte never counts as Space.
  assign is_space = rx_valid && (rx_byte == SPACE_CODE) && !ext &&
                    (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign press_ev = is_space && !brk && !key_down;
  assign rel_ev   = is_space && brk;

  // The acknowledge is applied first. A same-cycle event is then loaded
  // against the cleared latch, so it is never lost.
  always_comb begin
    next_state = space_state;
    next_held  = held_release;
    if (reset_space_state) begin
      next_state = held_release ? 2'd2 : 2'd0;
      next_held  = 1'b0;
    end
    if (press_ev && next_state == 2'd0)
      next_state = 2'd1;
    if (rel_ev) begin
      if (next_state == 2'd0)
        next_state = 2'd2;
      else if (next_state == 2'd1)
        next_held = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      key_down     <= 1'b0;
      held_release <= 1'b0;
      space_state  <= 2'd0;
    end else begin
      space_state  <= next_state;
      held_release <= next_held;
      if (rx_valid) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (is_space)
            key_down <= !brk;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_space_decoder.sv
module tb_ps2_space_decoder;

  localparam int T = 100;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       reset_space_state = 1'b0;
  logic [1:0] space_state;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;

  ps2_space_decoder #(.TIMEOUT_CYCLES(T), .SPACE_CODE(8'h29)) dut (
    .clock(clock), .resetn(resetn), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .reset_space_state(reset_space_state), .space_state(space_state),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  bit ack_arm = 1'b0;

  always @(negedge clock) begin
    if (resetn) begin
      rx_cnt  <= rx_cnt + int'(rx_valid);
      err_cnt <= err_cnt + int'(frame_error);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    reset_space_state = ack_arm & rx_valid;
  endtask

  task automatic send_bit(input logic b);
    tick();
    ps2_data  = b;
    ps2_clock = 1'b1;
    repeat (10) tick();
    ps2_clock = 1'b0;
    repeat (9) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    logic p;
    p = ~(^b) ^ bad_par;
    bits = {1'b1, p, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    tick();
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (10) tick();
  endtask

  task automatic ack();
    @(negedge clock);
    reset_space_state = 1'b1;
    @(negedge clock);
    reset_space_state = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Reference model: pending events form a queue of at most two entries
  // (press followed by a held release). The visible state is the head.
  int  q[$];
  bit  m_ext, m_brk, m_kd;

  function automatic void m_push(input int e);
    if (q.size() == 0) q.push_back(e);
    else if (e == 2 && q.size() == 1 && q[0] == 1) q.push_back(2);
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (b == 8'h29 && !m_ext) begin
        if (!m_brk) begin
          if (!m_kd) m_push(1);
          m_kd = 1;
        end else begin
          m_kd = 0;
          m_push(2);
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic int m_state();
    return (q.size() == 0) ? 0 : q[0];
  endfunction

  typedef struct {
    bit         is_ack;
    logic [7:0] data;
    bit         bad_par;
    int         exp_state;
    int         exp_rx;
    int         exp_err;
  } vec_t;

  vec_t tbl[29];

  initial begin
    int rx0, er0, n, r;
    logic [7:0] pick [5];
    logic [7:0] b;

    tbl[0]  = '{0, 8'h29, 0, 1, 1, 0};
    tbl[1]  = '{1, 8'h00, 0, 0, 0, 0};
    tbl[2]  = '{0, 8'hF0, 0, 0, 1, 0};
    tbl[3]  = '{0, 8'h29, 0, 2, 1, 0};
    tbl[4]  = '{1, 8'h00, 0, 0, 0, 0};
    tbl[5]  = '{0, 8'h29, 0, 1, 1, 0};
    tbl[6]  = '{1, 8'h00, 0, 0, 0, 0};
    tbl[7]  = '{0, 8'h29, 0, 0, 1, 0};
    tbl[8]  = '{1, 8'h00, 0, 0, 0, 0};
    tbl[9]  = '{0, 8'h29, 0, 0, 1, 0};
    tbl[10] = '{0, 8'hF0, 0, 0, 1, 0};
    tbl[11] = '{0, 8'h29, 0, 2, 1, 0};
    tbl[12] = '{1, 8'h00, 0, 0, 0, 0};
    tbl[13] = '{0, 8'h29, 0, 1, 1, 0};
    tbl[14] = '{0, 8'hF0, 0, 1, 1, 0};
    tbl[15] = '{0, 8'h29, 0, 1, 1, 0};
    tbl[16] = '{1, 8'h00, 0, 2, 0, 0};
    tbl[17] = '{1, 8'h00, 0, 0, 0, 0};
    tbl[18] = '{0, 8'hE0, 0, 0, 1, 0};
    tbl[19] = '{0, 8'h29, 0, 0, 1, 0};
    tbl[20] = '{0, 8'hE0, 0, 0, 1, 0};
    tbl[21] = '{0, 8'hF0, 0, 0, 1, 0};
    tbl[22] = '{0, 8'h29, 0, 0, 1, 0};
    tbl[23] = '{0, 8'h1C, 0, 0, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    tbl[24] = '{0, 8'h29, 1, 0, 0, 1};
`else
    tbl[24] = '{0, 8'h29, 1, 1, 1, 0};
`endif
    tbl[25] = '{1, 8'h00, 0, 0, 0, 0};
    tbl[26] = '{0, 8'hF0, 0, 0, 1, 0};
    tbl[27] = '{0, 8'h29, 0, 2, 1, 0};
    tbl[28] = '{1, 8'h00, 0, 0, 0, 0};

    repeat (3) @(negedge clock);
    chk("reset_state", space_state, 0);
    chk("reset_rx_byte", rx_byte, 0);
    chk("reset_strobes", {rx_valid, frame_error}, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 29; i++) begin
      rx0 = rx_cnt;
      er0 = err_cnt;
      if (tbl[i].is_ack) ack();
      else send_frame(tbl[i].data, tbl[i].bad_par);
      chk($sformatf("vec%0d_state", i), space_state, tbl[i].exp_state);
      chk($sformatf("vec%0d_rx", i), rx_cnt - rx0, tbl[i].exp_rx);
      chk($sformatf("vec%0d_err", i), err_cnt - er0, tbl[i].exp_err);
      if (!tbl[i].is_ack && tbl[i].exp_rx == 1)
        chk($sformatf("vec%0d_byte", i), rx_byte, tbl[i].data);
    end

    // Release arriving in the same cycle as an acknowledge of a pending press.
    send_frame(8'h29, 0);
    chk("coinc_press", space_state, 1);
    send_frame(8'hF0, 0);
    ack_arm = 1'b1;
    send_frame(8'h29, 0);
    ack_arm = 1'b0;
    chk("coinc_release", space_state, 2);
    ack();
    chk("coinc_cleared", space_state, 0);

    // Timeout after start bit plus 4 data bits.
    rx0 = rx_cnt;
    er0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n = 9;
    ps2_clock = 1'b1;
    while (!frame_error && n < 3 * T) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_latency", n, T + 3);
    repeat (3) @(negedge clock);
    chk("timeout_err", err_cnt - er0, 1);
    chk("timeout_no_rx", rx_cnt - rx0, 0);
    send_frame(8'h29, 0);
    chk("after_timeout_state", space_state, 1);
    chk("after_timeout_byte", rx_byte, 8'h29);

    // A start bit of 1 is a frame error.
    er0 = err_cnt;
    send_bit(1'b1);
    tick();
    ps2_clock = 1'b1;
    repeat (10) tick();
    chk("bad_start_err", err_cnt - er0, 1);
    chk("bad_start_state", space_state, 1);

    // Reset in the middle of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    resetn = 1'b0;
    #1;
    chk("midreset_state", space_state, 0);
    chk("midreset_byte", rx_byte, 0);
    chk("midreset_strobes", {rx_valid, frame_error}, 0);
    @(negedge clock);
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    rx0 = rx_cnt;
    send_frame(8'h29, 0);
    chk("post_reset_state", space_state, 1);
    chk("post_reset_rx", rx_cnt - rx0, 1);

    // Randomized byte/acknowledge sequence against the queue model.
    q = {1};
    m_ext = 0;
    m_brk = 0;
    m_kd = 1;
    pick[0] = 8'h29; pick[1] = 8'hF0; pick[2] = 8'hE0; pick[3] = 8'h1C; pick[4] = 8'h29;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        ack();
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        b = pick[r - 1];
        send_frame(b, 0);
        m_byte(b);
        chk($sformatf("rand%0d_byte", i), rx_byte, b);
      end
      chk($sformatf("rand%0d_state", i), space_state, m_state());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
